booth4_seq_mul: RTL and testbench

Iterative radix-4 Booth multiplier for the RV32M datapath, in the mul/div unit next to the divider. It generalises our fixed 32-bit Booth decode to a parametrised operand width. It retires one Booth digit per cycle and handles signed×signed, signed×unsigned and unsigned×unsigned operands (MUL, MULH, MULHSU, MULHU). It uses valid/ready handshakes on both sides, supports pipeline flush and has a zero-operand early-out.

---
 rtl/mul_div_pkg.sv | 27 ++
 rtl/booth4_pp_gen.sv | 37 +++
 rtl/booth4_seq_mul.sv | 166 ++++++++++++++++
 tb/tb_booth4_seq_mul.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_pkg.sv
// Shared definitions for the mul/div unit.
//
// Contents:
//   - FSM state encoding used by the iterative multiplier (IDLE/CALC/DONE)
//   - radix-4 Booth code points (three multiplier bits, LSB is the bit below the pair)
//   - booth_iter(): number of Booth digits needed for an XLEN-bit operand
//     (XLEN/2 + 1, the extra digit covers the extension bit of unsigned operands)
package mul_div_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] BOOTH_ZERO_P = 3'b000;
    localparam logic [2:0] BOOTH_P1_A   = 3'b001;
    localparam logic [2:0] BOOTH_P1_B   = 3'b010;
    localparam logic [2:0] BOOTH_P2     = 3'b011;
    localparam logic [2:0] BOOTH_M2     = 3'b100;
    localparam logic [2:0] BOOTH_M1_A   = 3'b101;
    localparam logic [2:0] BOOTH_M1_B   = 3'b110;
    localparam logic [2:0] BOOTH_ZERO_M = 3'b111;

    function automatic int booth_iter(input int xlen);
        return xlen / 2 + 1;
    endfunction

endpackage

// File: rtl/booth4_pp_gen.sv
// Radix-4 Booth partial-product generator (purely combinational).
//
// Ports:
//   code_i   [2:0]      Booth code {b[2i+1], b[2i], b[2i-1]}
//   a_ext_i  [XLEN:0]   multiplicand, already sign/zero extended by one bit
//   pp_o     [XLEN+2:0] signed partial product in {0, +a, +2a, -a, -2a}
//
// XLEN+3 bits are enough for -2a even when a_ext_i is the most negative value.
module booth4_pp_gen
    import mul_div_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]             code_i,
    input  logic signed [XLEN:0]   a_ext_i,
    output logic signed [XLEN+2:0] pp_o
);

    logic signed [XLEN+2:0] a1;
    logic signed [XLEN+2:0] a2;

    assign a1 = {{2{a_ext_i[XLEN]}}, a_ext_i};
    assign a2 = {a_ext_i[XLEN], a_ext_i, 1'b0};

    always_comb begin
        pp_o = '0;
        case (code_i)
            BOOTH_ZERO_P, BOOTH_ZERO_M: pp_o = '0;
            BOOTH_P1_A, BOOTH_P1_B:     pp_o = a1;
            BOOTH_P2:                   pp_o = a2;
            BOOTH_M2:                   pp_o = -a2;
            BOOTH_M1_A, BOOTH_M1_B:     pp_o = -a1;
            default:                    pp_o = '0;
        endcase
    end

endmodule

// File: rtl/booth4_seq_mul.sv
// Iterative radix-4 Booth multiplier (MUL/MULH/MULHSU/MULHU), one digit per cycle.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   flush                  abort any operation; wins over every handshake
//   start_valid/ready      request handshake (ready only in IDLE and not flushing)
//   op_a, op_b             multiplicand / multiplier
//   a_unsign, b_unsign     treat the respective operand as unsigned
//   hi_sel                 1: upper product half, 0: lower half
//   res_valid/ready        result handshake; result is held while stalled
//   result                 selected product half (registered)
//   busy                   state is not IDLE
//
// Digit i is weighted by 4^i: the partial product is sign-extended to the
// accumulator width and shifted left by 2*cnt before the add, so the
// multiplier register only has to shift right by one digit per cycle.
module booth4_seq_mul
    import mul_div_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int ZERO_SKIP = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            start_valid,
    output logic            start_ready,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            a_unsign,
    input  logic            b_unsign,
    input  logic            hi_sel,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int ITER  = booth_iter(XLEN);
    localparam int CNT_W = $clog2(ITER);
    localparam int ACC_W = 2 * XLEN + 4;
    localparam int PP_W  = XLEN + 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    logic [1:0]              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [XLEN:0]    a_q, a_d;
    logic [XLEN+1:0]         b_q, b_d;
    logic                    bm1_q, bm1_d;    // multiplier bit just below the current digit
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    hi_q, hi_d;
    logic [XLEN-1:0]         res_q, res_d;
    logic                    rvld_q, rvld_d;

    logic [2:0]              code;
    logic signed [PP_W-1:0]  pp;
    logic signed [ACC_W-1:0] pp_ext;
    logic signed [ACC_W-1:0] pp_sh;
    logic signed [ACC_W-1:0] acc_sum;
    logic                    zero_hit;

    assign code = {b_q[1], b_q[0], bm1_q};

    booth4_pp_gen #(
        .XLEN (XLEN)
    ) u_pp_gen (
        .code_i  (code),
        .a_ext_i (a_q),
        .pp_o    (pp)
    );

    assign pp_ext  = {{(ACC_W - PP_W){pp[PP_W-1]}}, pp};
    assign pp_sh   = pp_ext <<< {cnt_q, 1'b0};
    assign acc_sum = acc_q + pp_sh;

    assign zero_hit = (ZERO_SKIP != 0) && ((op_a == '0) || (op_b == '0));

    assign start_ready = (state_q == ST_IDLE) && !flush;
    assign busy        = (state_q != ST_IDLE);
    assign res_valid   = rvld_q;
    assign result      = res_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        bm1_d   = bm1_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        res_d   = res_q;
        rvld_d  = rvld_q;

        if (flush) begin
            state_d = ST_IDLE;
            rvld_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_valid) begin
                        a_d   = a_unsign ? {1'b0, op_a} : {op_a[XLEN-1], op_a};
                        b_d   = b_unsign ? {2'b00, op_b} : {{2{op_b[XLEN-1]}}, op_b};
                        bm1_d = 1'b0;
                        cnt_d = '0;
                        acc_d = '0;
                        hi_d  = hi_sel;
                        if (zero_hit) begin
                            state_d = ST_DONE;
                            res_d   = '0;
                            rvld_d  = 1'b1;
                        end else begin
                            state_d = ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    acc_d = acc_sum;
                    b_d   = {2'b00, b_q[XLEN+1:2]};
                    bm1_d = b_q[1];
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                        rvld_d  = 1'b1;
                        res_d   = hi_q ? acc_sum[2*XLEN-1:XLEN] : acc_sum[XLEN-1:0];
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        state_d = ST_IDLE;
                        rvld_d  = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    rvld_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            bm1_q   <= 1'b0;
            acc_q   <= '0;
            hi_q    <= 1'b0;
            res_q   <= '0;
            rvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            bm1_q   <= bm1_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            res_q   <= res_d;
            rvld_q  <= rvld_d;
        end
    end

endmodule

// File: tb/tb_booth4_seq_mul.sv
module tb_booth4_seq_mul;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        start_valid;
    logic        start_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        a_unsign;
    logic        b_unsign;
    logic        hi_sel;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] result;
    logic        busy;

    int tests;
    int failed;

    booth4_seq_mul #(
        .XLEN      (32),
        .ZERO_SKIP (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .a_unsign    (a_unsign),
        .b_unsign    (b_unsign),
        .hi_sel      (hi_sel),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .result      (result),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request, wait for the result, check latency and value, retire it.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic au, input logic bu, input logic hs,
                          input logic [31:0] exp_res, input int exp_lat);
        int n;
        n = 0;
        while (!start_ready && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_start_ready"}, 64'(start_ready), 64'd1);
        op_a = a; op_b = b; a_unsign = au; b_unsign = bu; hi_sel = hs;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        n = 0;
        while (!res_valid && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
        chk({tag, "_result"}, 64'(result), 64'(exp_res));
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({tag, "_ready_after_retire"}, 64'(start_ready), 64'd1);
        chk({tag, "_valid_after_retire"}, 64'(res_valid), 64'd0);
    endtask

    initial begin
        int  n;
        bit  seen;
        logic [31:0] held;

        tests = 0;
        failed = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        start_valid = 1'b0;
        op_a = '0; op_b = '0;
        a_unsign = 1'b0; b_unsign = 1'b0; hi_sel = 1'b0;
        res_ready = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_start_ready", 64'(start_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        #2 rst_n = 1'b1;
        tick();

        // 7 * -3 = -21, lower half, full latency
        run_op("sgn_lo", 32'd7, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFEB, 17);
        // (-2^31)^2 = 2^62, upper half
        run_op("sgn_hi_worst", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 32'h4000_0000, 17);
        // (2^32-1)^2 = 0xFFFFFFFE_00000001
        run_op("uns_hi", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, 17);
        run_op("uns_lo", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 32'h0000_0001, 17);
        // -1 * (2^32-1) = 0xFFFFFFFF_00000001
        run_op("mulhsu_hi", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 17);
        // -2 * 3 = -6, upper half all ones
        run_op("sgn_neg_hi", 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 17);
        // zero multiplier, upper half requested: early-out
        run_op("zero_b", 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0, 1'b1, 32'h0, 0);

        // Zero multiplicand early-out with backpressure
        op_a = 32'd0; op_b = 32'h1234_5678; a_unsign = 1'b0; b_unsign = 1'b0; hi_sel = 1'b0;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        chk("zero_a_valid_now", 64'(res_valid), 64'd1);
        chk("zero_a_result", 64'(result), 64'd0);
        held = result;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (res_valid !== 1'b1 || result !== held || start_ready !== 1'b0) seen = 1'b1;
        end
        chk("backpressure_stable", 64'(seen), 64'd0);
        chk("backpressure_start_ready", 64'(start_ready), 64'd0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("retire_start_ready", 64'(start_ready), 64'd1);
        chk("retire_res_valid", 64'(res_valid), 64'd0);

        // Flush 5 cycles after accept, with a competing start request
        op_a = 32'd9; op_b = 32'd9; hi_sel = 1'b0;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("pre_flush_busy", 64'(busy), 64'd1);
        flush = 1'b1;
        start_valid = 1'b1;
        #1;
        chk("flush_start_ready", 64'(start_ready), 64'd0);
        tick();
        flush = 1'b0;
        start_valid = 1'b0;
        chk("flush_idle", 64'(busy), 64'd0);
        chk("flush_res_valid", 64'(res_valid), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (res_valid !== 1'b0) seen = 1'b1;
        end
        chk("flush_no_result", 64'(seen), 64'd0);
        run_op("after_flush", 32'd3, 32'd5, 1'b0, 1'b0, 1'b0, 32'd15, 17);

        // Asynchronous reset mid-CALC
        op_a = 32'd9; op_b = 32'd9; hi_sel = 1'b0;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_start_ready", 64'(start_ready), 64'd1);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_res_valid", 64'(res_valid), 64'd0);
        chk("arst_result", 64'(result), 64'd0);
        #1 rst_n = 1'b1;
        n = 0;
        seen = 1'b0;
        while (n < 25) begin
            tick();
            if (res_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
            n++;
        end
        chk("arst_no_result", 64'(seen), 64'd0);
        run_op("after_reset", 32'hFFFF_FFFB, 32'hFFFF_FFFB, 1'b0, 1'b0, 1'b0, 32'd25, 17);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
